// File: rtl/acmp_scan_ctrl.sv
// acmp_scan_ctrl: time-shares one comparator across NCH analog channels.
// Each channel is selected, given a programmable settle time, and then sampled.
// The sample is taken from a 2-flop synchronizer and latched into per-channel
// status and valid bits. A change-pending interrupt is raised when a channel
// that already holds a valid result reports a different value.
// Optional build macro: ACMP_SCAN_CTRL_DEBOUNCE_EN.
// When it is defined, status only updates after two consecutive agreeing
// samples of the same channel.
module acmp_scan_ctrl #(
    parameter int NCH      = 4,
    parameter int SEL_W    = 2,
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cfg_en,
    input  logic [NCH-1:0]      cfg_chmask,
    input  logic [SETTLE_W-1:0] cfg_settle,
    output logic                acmp_en,
    output logic [SEL_W-1:0]    acmp_sel,
    input  logic                acmp_out,
    output logic [NCH-1:0]      status,
    output logic [NCH-1:0]      valid,
    output logic [NCH-1:0]      irq_pend,
    input  logic [NCH-1:0]      irq_clr,
    output logic                irq
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

    state_t              state, state_nxt;
    logic [SETTLE_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0]    sel_nxt;
    logic                en_nxt;
    logic                ph, ph_nxt;     // SAMPLE phase: 0 = flush, 1 = capture
    logic                sync_ff1, sync_ff2;
    logic                run, capture, stop;
    logic                take, accept;
    logic [NCH-1:0]      pend_set;
`ifdef ACMP_SCAN_CTRL_DEBOUNCE_EN
    logic [NCH-1:0]      cand;           // last sample seen per channel
    logic [NCH-1:0]      cand_vld;       // cand holds a sample from this session
`endif

    // Lowest set bit of the mask.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] m);
        lowest_set = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i]) lowest_set = SEL_W'(i);
    endfunction

    // Round-robin: lowest set bit strictly above cur, else wrap to the lowest set bit.
    function automatic logic [SEL_W-1:0] next_after(input logic [NCH-1:0] m,
                                                    input logic [SEL_W-1:0] cur);
        logic found;
        found      = 1'b0;
        next_after = lowest_set(m);
        for (int i = 0; i < NCH; i++)
            if (!found && m[i] && (i > int'(cur))) begin
                next_after = SEL_W'(i);
                found      = 1'b1;
            end
    endfunction

    assign run = cfg_en && (|cfg_chmask);
    assign irq = |irq_pend;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= acmp_out;
            sync_ff2 <= sync_ff1;
        end
    end

    // Scan FSM state, settle counter, mux select and comparator enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            acmp_sel <= '0;
            acmp_en  <= 1'b0;
            ph       <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            acmp_sel <= sel_nxt;
            acmp_en  <= en_nxt;
            ph       <= ph_nxt;
        end
    end

    // Next-state logic; a disable at any point aborts the in-flight sample.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = acmp_sel;
        en_nxt    = acmp_en;
        ph_nxt    = ph;
        capture   = 1'b0;
        stop      = 1'b0;
        case (state)
            IDLE: begin
                en_nxt = 1'b0;
                if (run) begin
                    sel_nxt   = lowest_set(cfg_chmask);
                    en_nxt    = 1'b1;
                    cnt_nxt   = cfg_settle;
                    ph_nxt    = 1'b0;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (!run) begin
                    stop = 1'b1;
                end else if (cnt == '0) begin
                    ph_nxt    = 1'b0;
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt - SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                if (!run) begin
                    stop = 1'b1;
                end else if (!ph) begin
                    ph_nxt = 1'b1;
                end else begin
                    capture   = 1'b1;
                    sel_nxt   = next_after(cfg_chmask, acmp_sel);
                    cnt_nxt   = cfg_settle;
                    ph_nxt    = 1'b0;
                    state_nxt = SETTLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt = IDLE;
            en_nxt    = 1'b0;
            ph_nxt    = 1'b0;
        end
    end

    // Decide whether this capture updates status, and whether it raises a change flag.
    always_comb begin
        pend_set = '0;
        take     = capture && cfg_chmask[acmp_sel];
`ifdef ACMP_SCAN_CTRL_DEBOUNCE_EN
        accept   = take && cand_vld[acmp_sel] && (cand[acmp_sel] == sync_ff2);
`else
        accept   = take;
`endif
        if (accept && valid[acmp_sel] && (sync_ff2 != status[acmp_sel]))
            pend_set[acmp_sel] = 1'b1;
    end

    // Per-channel result, valid and interrupt-pending registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status   <= '0;
            valid    <= '0;
            irq_pend <= '0;
`ifdef ACMP_SCAN_CTRL_DEBOUNCE_EN
            cand     <= '0;
            cand_vld <= '0;
`endif
        end else begin
            // A set wins over a clear arriving on the same cycle.
            irq_pend <= (irq_pend & ~irq_clr) | pend_set;
            if (stop) begin
                valid <= '0;
`ifdef ACMP_SCAN_CTRL_DEBOUNCE_EN
                cand     <= '0;
                cand_vld <= '0;
`endif
            end else begin
`ifdef ACMP_SCAN_CTRL_DEBOUNCE_EN
                if (take) begin
                    cand[acmp_sel]     <= sync_ff2;
                    cand_vld[acmp_sel] <= 1'b1;
                end
`endif
                if (accept) begin
                    status[acmp_sel] <= sync_ff2;
                    valid[acmp_sel]  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_acmp_scan_ctrl.sv
// Testbench for acmp_scan_ctrl (NCH=4).
// Each table record describes one channel slot: the expected select value, the
// comparator value to drive, any irq_clr pulses, and the expected status,
// valid, irq_pend and irq after that slot's capture.
module tb_acmp_scan_ctrl;
    localparam int NCH = 4, SEL_W = 2, SETTLE_W = 8;

    logic                clk = 1'b0;
    logic                resetn, cfg_en, acmp_out, acmp_en, irq;
    logic [NCH-1:0]      cfg_chmask, status, valid, irq_pend, irq_clr;
    logic [SETTLE_W-1:0] cfg_settle;
    logic [SEL_W-1:0]    acmp_sel;

    always #5 clk = ~clk;

    acmp_scan_ctrl #(.NCH(NCH), .SEL_W(SEL_W), .SETTLE_W(SETTLE_W)) dut (
        .clk(clk), .resetn(resetn), .cfg_en(cfg_en), .cfg_chmask(cfg_chmask),
        .cfg_settle(cfg_settle), .acmp_en(acmp_en), .acmp_sel(acmp_sel),
        .acmp_out(acmp_out), .status(status), .valid(valid),
        .irq_pend(irq_pend), .irq_clr(irq_clr), .irq(irq)
    );

    typedef struct {
        logic [1:0] sel;
        logic       val;
        logic [3:0] clr;
        logic [3:0] clr_cap;
        logic [3:0] st;
        logic [3:0] vl;
        logic [3:0] pd;
        logic       irq_e;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic rec_t mk(input logic [1:0] sel, input logic val,
                                input logic [3:0] clr, input logic [3:0] clr_cap,
                                input logic [3:0] st, input logic [3:0] vl,
                                input logic [3:0] pd, input logic irq_e);
        rec_t r;
        r.sel = sel; r.val = val; r.clr = clr; r.clr_cap = clr_cap;
        r.st = st; r.vl = vl; r.pd = pd; r.irq_e = irq_e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one channel slot of len cycles, starting just after the edge that selected it.
    task automatic run_slot(input rec_t r, input int len);
        rec_t e;
        logic hold_ok;
        chk("slot_sel", acmp_sel, r.sel);
        acmp_out = r.val;
        irq_clr  = r.clr;
        sb.push_back(r);
        hold_ok = 1'b1;
        for (int i = 1; i < len; i++) begin
            @(posedge clk); #1;
            irq_clr = '0;
            if (acmp_sel !== r.sel || acmp_en !== 1'b1) hold_ok = 1'b0;
        end
        chk("slot_hold", hold_ok, 1);
        irq_clr = r.clr_cap;
        @(posedge clk); #1;
        irq_clr = '0;
        e = sb.pop_front();
        chk("cap_status", status, e.st);
        chk("cap_valid", valid, e.vl);
        chk("cap_pend", irq_pend, e.pd);
        chk("cap_irq", irq, e.irq_e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
`ifndef ACMP_SCAN_CTRL_DEBOUNCE_EN
        rec_t t[12];
        t[0]  = mk(0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0);
        t[1]  = mk(1, 1, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 0);
        t[2]  = mk(3, 0, 4'b0000, 4'b0000, 4'b0011, 4'b1011, 4'b0000, 0);
        t[3]  = mk(0, 1, 4'b0000, 4'b0000, 4'b0011, 4'b1011, 4'b0000, 0);
        t[4]  = mk(1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b1011, 4'b0010, 1);
        t[5]  = mk(3, 1, 4'b0000, 4'b0000, 4'b1001, 4'b1011, 4'b1010, 1);
        t[6]  = mk(0, 1, 4'b0010, 4'b0000, 4'b1001, 4'b1011, 4'b1000, 1);
        t[7]  = mk(1, 0, 4'b1000, 4'b0000, 4'b1001, 4'b1011, 4'b0000, 0);
        t[8]  = mk(3, 1, 4'b0000, 4'b0000, 4'b1001, 4'b1011, 4'b0000, 0);
        t[9]  = mk(0, 0, 4'b0000, 4'b0001, 4'b1000, 4'b1011, 4'b0001, 1);
        t[10] = mk(1, 1, 4'b0001, 4'b0000, 4'b1010, 4'b1011, 4'b0010, 1);
        t[11] = mk(3, 1, 4'b0000, 4'b0000, 4'b1010, 4'b1011, 4'b0010, 1);
`else
        rec_t d[9];
        d[0] = mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        d[1] = mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        d[2] = mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        d[3] = mk(0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0);
        d[4] = mk(0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0);
        d[5] = mk(0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0);
        d[6] = mk(0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0);
        d[7] = mk(0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0);
        d[8] = mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1);
`endif
        resetn = 1'b0; cfg_en = 1'b0; cfg_chmask = '0; cfg_settle = '0;
        acmp_out = 1'b0; irq_clr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", acmp_en, 0);
        chk("rst_sel", acmp_sel, 0);
        chk("rst_status", status, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pend", irq_pend, 0);
        chk("rst_irq", irq, 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;

`ifndef ACMP_SCAN_CTRL_DEBOUNCE_EN
        // Round-robin scan over mask 1011 with a 4-cycle settle (6 cycles per channel).
        cfg_chmask = 4'b1011; cfg_settle = 8'd3; cfg_en = 1'b1;
        #1;
        chk("en_before_edge", acmp_en, 0);
        @(posedge clk); #1;
        chk("en_rise", acmp_en, 1);
        for (int k = 0; k < 12; k++) run_slot(t[k], 6);

        // Disable mid-SETTLE: valid clears, status and irq_pend are retained.
        cfg_en = 1'b0;
        @(posedge clk); #1;
        chk("dis_en", acmp_en, 0);
        chk("dis_valid", valid, 0);
        chk("dis_status", status, 4'b1010);
        chk("dis_pend", irq_pend, 4'b0010);
        chk("dis_irq", irq, 1);

        // Single-channel scan; first sample after enable sets no pend.
        cfg_chmask = 4'b0100; cfg_en = 1'b1;
        @(posedge clk); #1;
        run_slot(mk(2, 1, 4'b0000, 4'b0000, 4'b1110, 4'b0100, 4'b0010, 1), 6);
        chk("single_sel", acmp_sel, 2);

        // Mask dropped to zero during SAMPLE: capture is discarded.
        acmp_out = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cfg_chmask = 4'b0000;
        @(posedge clk); #1;
        chk("abort_en", acmp_en, 0);
        chk("abort_valid", valid, 0);
        chk("abort_status", status, 4'b1110);
        chk("abort_pend", irq_pend, 4'b0010);
        irq_clr = 4'b0010;
        @(posedge clk); #1;
        irq_clr = '0;
        chk("clr_pend", irq_pend, 0);
        chk("clr_irq", irq, 0);

        // Asynchronous reset mid-SETTLE, then restart from the lowest channel.
        cfg_chmask = 4'b1010;
        @(posedge clk); #1;
        chk("rr_start_sel", acmp_sel, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("rr_next_sel", acmp_sel, 3);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("arst_en", acmp_en, 0);
        chk("arst_status", status, 0);
        chk("arst_valid", valid, 0);
        chk("arst_irq", irq, 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        chk("restart_en", acmp_en, 1);
        chk("restart_sel", acmp_sel, 1);
`else
        // Debounced single-channel scan, settle of one cycle (3 cycles per sample).
        cfg_chmask = 4'b0001; cfg_settle = 8'd0; cfg_en = 1'b1;
        @(posedge clk); #1;
        chk("en_rise", acmp_en, 1);
        for (int k = 0; k < 9; k++) run_slot(d[k], 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/acmp_scan_ctrl.md
Name: acmp_scan_ctrl

Overview:
- Time-shares one acmpc01_3v3 comparator among NCH analog input pairs.
- Drives the comparator EN pin and an analog input-mux select. Waits a programmable settle time, then samples the comparator output through a synchronizer.
- Keeps a per-channel result/valid status and raises change interrupts.
- Sits between the SoC register bank (cfg/status/irq) and the analog macro boundary.

Parameters:
- NCH, 4, number of scanned channels (1..16).
- SEL_W, 2, width of mux select; 2**SEL_W >= NCH.
- SETTLE_W, 8, width of settle-count config.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- cfg_en  in  1  scan enable.
- cfg_chmask  in  NCH  channels included in the scan.
- cfg_settle  in  SETTLE_W  settle cycles minus one after EN/select change.
- acmp_en  out  1  comparator EN pin.
- acmp_sel  out  SEL_W  analog mux channel select.
- acmp_out  in  1  raw comparator OUT; asynchronous to clk.
- status  out  NCH  latest comparison result per channel (1 = INP > INN).
- valid  out  NCH  status bit holds a sample from the current scan session.
- irq_pend  out  NCH  per-channel change-pending flags.
- irq_clr  in  NCH  write-1-to-clear pulses for irq_pend.
- irq  out  1  OR of irq_pend.

Behaviour:
- Reset values:
  - acmp_en=0, acmp_sel=0.
  - status=0, valid=0, irq_pend=0, irq=0.
  - Synchronizer flops=0, settle counter=0, state=IDLE.
- acmp_out passes through a 2-flop synchronizer; only its output is used.
- States: IDLE, SETTLE, SAMPLE.
- IDLE:
  - If cfg_en=1 and cfg_chmask!=0: load acmp_sel with the lowest set mask bit, set acmp_en=1, load cnt=cfg_settle, go to SETTLE.
  - Otherwise hold acmp_en=0.
- SETTLE:
  - Decrement cnt each cycle.
  - When cnt==0, go to SAMPLE. SETTLE therefore lasts exactly cfg_settle+1 cycles.
  - cfg_settle is sampled only when cnt is loaded.
- SAMPLE:
  - Lasts exactly 2 cycles to flush the synchronizer.
  - On the last cycle, capture: if cfg_chmask[sel]=1, then status[sel]<=sync, valid[sel]<=1, and irq_pend[sel]<=1 if valid[sel] was already 1 and sync != status[sel].
  - The first sample after enable never sets irq_pend.
  - If cfg_chmask[sel]=0 at capture, the sample is discarded.
- Next-channel selection, same cycle as capture:
  - Pick the lowest set mask bit strictly above sel, wrapping to the lowest set bit (round-robin).
  - Reload cnt, go to SETTLE. acmp_en stays 1.
  - If only one channel is set, sel is unchanged, but the settle count still applies.
- Disable:
  - If cfg_en=0 or cfg_chmask=0 at any state's transition point, go to IDLE next cycle: acmp_en=0, valid<=0.
  - status is retained; irq_pend is retained.
  - This takes effect mid-SETTLE/SAMPLE too; the in-flight sample is discarded.
- Mask changes mid-scan take effect at the next selection only; the current settle/sample sequence completes.
- irq_clr: clears the matching irq_pend bits. A same-cycle set and clear on one bit leaves it set.
- irq is registered: irq = |irq_pend, with one cycle lag allowed. Specified here as a combinational OR of the registered irq_pend.
- An X on acmp_out (undefined analog input) propagates into status in simulation. No filtering is applied.
- Cycle budget per channel: cfg_settle+1 + 2 cycles.

Optional Feature:
- Macro: ACMP_SCAN_CTRL_DEBOUNCE_EN.
- Defined:
  - Each channel has a candidate bit.
  - status[ch] updates (and can set irq_pend) only when two consecutive accepted samples of that channel agree. The candidate is loaded on each sample.
  - valid[ch] sets after the first two agreeing samples.
  - Candidates reset to 0 and are cleared on disable.
- Undefined: single-sample update as above; no candidate registers exist.

Test Plan:
- Reset mid-SETTLE with cfg_en=1 -> acmp_en=0, status=0, valid=0, irq=0 asynchronously; the scan restarts from the lowest channel after release.
- NCH=4, mask=4'b1011, cfg_settle=3 -> acmp_sel sequence 0,1,3,0,...; each channel is held 6 cycles; acmp_en rises 1 cycle after cfg_en.
- Channel 1 acmp_out steady 1, then toggled to 0 -> status[1] goes 1->0 on the next ch1 capture, irq_pend[1]=1, irq=1. irq_clr=4'b0010 then clears it.
- irq_clr[1] pulsed on the same cycle a new change sets irq_pend[1] -> irq_pend[1] remains 1.
- mask 4'b0100 changed to 0 during SAMPLE -> no capture, acmp_en=0 next cycle, valid=0, status[2] retained.
- With ACMP_SCAN_CTRL_DEBOUNCE_EN: ch0 samples 1,0,1,1 -> status[0] updates only after the 4th sample; a single glitch sample produces no irq.
